// File: rtl/beam_trigger_arbiter.sv
// beam_trigger_arbiter: collects per-beam trigger hits into pending bits and
// serializes the pending beams as a round-robin stream of beam indices on a
// valid/ready output. It also keeps a saturating count of hits that were lost
// because their beam was already pending.
// Optional build macro BEAM_TRIG_MASK_EN adds mask_i. A 1 on mask_i[b] stops
// beam b from setting its pending bit or counting as dropped. Bits that are
// already pending still drain normally.
module beam_trigger_arbiter #(
  parameter int NUM_BEAM = 48,
  parameter int IDX_W    = 6,
  parameter int DROP_W   = 16
) (
  input  logic                aclk,
  input  logic                aclk_rst,
  input  logic [NUM_BEAM-1:0] trig_i,
`ifdef BEAM_TRIG_MASK_EN
  input  logic [NUM_BEAM-1:0] mask_i,
`endif
  input  logic                clear_i,
  output logic [IDX_W-1:0]    m_beam_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [NUM_BEAM-1:0] pending_o,
  output logic [DROP_W-1:0]   dropped_o
);

  logic [NUM_BEAM-1:0] pending_q, pending_d;
  logic [IDX_W-1:0]    rr_ptr_q,  rr_ptr_d;
  logic [IDX_W-1:0]    beam_q,    beam_d;
  logic                valid_q,   valid_d;
  logic [DROP_W-1:0]   dropped_q, dropped_d;

  logic [NUM_BEAM-1:0] en;
  logic [NUM_BEAM-1:0] hit;
  logic [NUM_BEAM-1:0] grant_vec;
  logic                slot_free;
  logic                do_grant;
  logic                drop_any;
  logic                found_hi;
  logic                found_any;
  logic [IDX_W-1:0]    idx_hi;
  logic [IDX_W-1:0]    idx_any;
  logic [IDX_W-1:0]    grant_idx;

`ifdef BEAM_TRIG_MASK_EN
  assign en = ~mask_i;
`else
  assign en = '1;
`endif

  assign hit       = trig_i & en;
  assign slot_free = ~valid_q | m_ready_i;
  assign do_grant  = slot_free & found_any;

  // Rotated priority encode. Take the lowest pending bit at or above rr_ptr.
  // If there is none, wrap around and take the lowest pending bit overall.
  // Both searches are flat and run in parallel, so the grant still lands in
  // the same cycle as the search.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int unsigned b = 0; b < NUM_BEAM; b++) begin
      if (pending_q[b] && !found_any) begin
        found_any = 1'b1;
        idx_any   = IDX_W'(b);
      end
      if (pending_q[b] && !found_hi && (b >= 32'(rr_ptr_q))) begin
        found_hi = 1'b1;
        idx_hi   = IDX_W'(b);
      end
    end
    grant_idx = found_hi ? idx_hi : idx_any;
  end

  // One-hot grant vector for the beam selected this cycle.
  always_comb begin
    grant_vec = '0;
    for (int unsigned b = 0; b < NUM_BEAM; b++) begin
      grant_vec[b] = do_grant && (grant_idx == IDX_W'(b));
    end
  end

  // A beam drops when it is hit while already pending and is not being granted.
  assign drop_any = |(hit & pending_q & ~grant_vec);

  // Next-state logic: pending update, grant/hold of the output slot,
  // advance of the round-robin pointer, and the drop counter.
  always_comb begin
    pending_d = pending_q;
    rr_ptr_d  = rr_ptr_q;
    beam_d    = beam_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;
    if (clear_i) begin
      pending_d = '0;
      rr_ptr_d  = '0;
      valid_d   = 1'b0;
      dropped_d = '0;
    end else begin
      // A set wins over a clear: a hit re-arms a beam granted in the same cycle.
      pending_d = (pending_q & ~grant_vec) | hit;
      if (do_grant) begin
        beam_d   = grant_idx;
        valid_d  = 1'b1;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_BEAM - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else if (slot_free) begin
        valid_d = 1'b0;
      end
      if (drop_any && (dropped_q != '1)) begin
        dropped_d = dropped_q + DROP_W'(1);
      end
    end
  end

  // State registers, reset asynchronously.
  always_ff @(posedge aclk or posedge aclk_rst) begin
    if (aclk_rst) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      beam_q    <= '0;
      valid_q   <= 1'b0;
      dropped_q <= '0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      beam_q    <= beam_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign m_beam_o  = beam_q;
  assign m_valid_o = valid_q;
  assign pending_o = pending_q;
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_beam_trigger_arbiter.sv
// Self-checking bench for beam_trigger_arbiter. It checks directed scenarios
// plus random traffic against a cycle-level reference model of the arbiter.
module tb_beam_trigger_arbiter;
  localparam int NB = 48;
  localparam int IW = 6;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aclk_rst = 1'b1;
  logic [NB-1:0] trig_i = '0;
  logic [NB-1:0] mask_v = '0;
  logic          clear_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic [IW-1:0] m_beam_o;
  logic          m_valid_o;
  logic [NB-1:0] pending_o;
  logic [DW-1:0] dropped_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  bit mp[NB];
  int mrr;
  bit mval;
  int mbeam;
  int mdrop;

  beam_trigger_arbiter #(.NUM_BEAM(NB), .IDX_W(IW), .DROP_W(DW)) dut (
    .aclk      (aclk),
    .aclk_rst  (aclk_rst),
    .trig_i    (trig_i),
`ifdef BEAM_TRIG_MASK_EN
    .mask_i    (mask_v),
`endif
    .clear_i   (clear_i),
    .m_beam_o  (m_beam_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .pending_o (pending_o),
    .dropped_o (dropped_o)
  );

  always #5 aclk = ~aclk;

  function automatic logic [NB-1:0] oh(input int b);
    logic [NB-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [NB-1:0] model_pend();
    logic [NB-1:0] v;
    for (int b = 0; b < NB; b++) v[b] = mp[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) mp[b] = 1'b0;
    mrr = 0; mval = 1'b0; mbeam = 0; mdrop = 0;
  endtask

  // Advance the model by one clock. The inputs are the values sampled at the edge.
  task automatic model_step(input logic [NB-1:0] t, input bit rdy, input bit clr);
    int g;
    bit lost;
    logic [NB-1:0] h;
`ifdef BEAM_TRIG_MASK_EN
    h = t & ~mask_v;
`else
    h = t;
`endif
    if (clr) begin
      for (int b = 0; b < NB; b++) mp[b] = 1'b0;
      mrr = 0; mval = 1'b0; mdrop = 0;
    end else begin
      g = -1;
      if (!mval || rdy) begin
        for (int k = 0; k < NB; k++) begin
          if (g < 0 && mp[(mrr + k) % NB]) g = (mrr + k) % NB;
        end
      end
      lost = 1'b0;
      for (int b = 0; b < NB; b++) begin
        if (h[b] && mp[b] && b != g) lost = 1'b1;
        mp[b] = (mp[b] && b != g) || h[b];
      end
      if (g >= 0) begin
        mval = 1'b1; mbeam = g; mrr = (g + 1) % NB;
      end else if (!mval || rdy) begin
        mval = 1'b0;
      end
      if (lost && mdrop < (1 << DW) - 1) mdrop++;
    end
  endtask

  // Drive one cycle. Returns at posedge+1 with the model advanced past that edge.
  task automatic cycle(input logic [NB-1:0] t, input bit rdy, input bit clr);
    trig_i = t; m_ready_i = rdy; clear_i = clr;
    @(posedge aclk);
    model_step(t, rdy, clr);
    #1;
  endtask

  task automatic do_reset();
    trig_i = '0; m_ready_i = 1'b0; clear_i = 1'b0; mask_v = '0;
    aclk_rst = 1'b1;
    repeat (2) @(posedge aclk);
    #2 aclk_rst = 1'b0;
    model_reset();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge aclk); #1;
    tests_run++;
    if ({m_valid_o, m_beam_o, pending_o, dropped_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0b beam=%0d pend=%h drop=%0d, required all zero", m_valid_o, m_beam_o, pending_o, dropped_o);
    end
    do_reset();
    cycle(oh(5) | oh(6), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(oh(5), 1'b0, 1'b0);
    cycle(oh(5), 1'b0, 1'b0);
    // Assert reset between clock edges. The outputs must clear with no edge.
    #2 aclk_rst = 1'b1;
    #1;
    tests_run++;
    if ({m_valid_o, pending_o, dropped_o} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%0b pend=%h drop=%0d, required all zero", m_valid_o, pending_o, dropped_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    cycle(oh(5), 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b0 || pending_o !== oh(5)) begin
      tests_failed++;
      $display("FAIL single_n1: valid=%0b pend=%h, required valid=0 pend=%h", m_valid_o, pending_o, oh(5));
    end
    cycle('0, 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b1 || m_beam_o !== IW'(5) || pending_o !== '0) begin
      tests_failed++;
      $display("FAIL single_n2: valid=%0b beam=%0d pend=%h, required valid=1 beam=5 pend=0", m_valid_o, m_beam_o, pending_o);
    end
    cycle('0, 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b0 || dropped_o !== '0) begin
      tests_failed++;
      $display("FAIL single_n3: valid=%0b drop=%0d, required valid=0 drop=0", m_valid_o, dropped_o);
    end
  endtask

  task automatic test_wrap();
    int exp1[3] = '{3, 10, 47};
    int exp2[2] = '{0, 3};
    do_reset();
    cycle(oh(3) | oh(10) | oh(47), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1'b1, 1'b0);
      tests_run++;
      if (m_valid_o !== 1'b1 || m_beam_o !== IW'(exp1[k])) begin
        tests_failed++;
        $display("FAIL wrap_seq%0d: valid=%0b beam=%0d, required valid=1 beam=%0d", k, m_valid_o, m_beam_o, exp1[k]);
      end
    end
    cycle(oh(0) | oh(3), 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_idle: valid=%0b, required 0", m_valid_o);
    end
    for (int k = 0; k < 2; k++) begin
      cycle('0, 1'b1, 1'b0);
      tests_run++;
      if (m_valid_o !== 1'b1 || m_beam_o !== IW'(exp2[k])) begin
        tests_failed++;
        $display("FAIL wrap_after%0d: valid=%0b beam=%0d, required valid=1 beam=%0d", k, m_valid_o, m_beam_o, exp2[k]);
      end
    end
  endtask

  task automatic test_stall();
    int n7;
    do_reset();
    cycle(oh(7), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(oh(7), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(oh(7), 1'b0, 1'b0);
    // The first hit sits in the stalled slot, the second is pending, the third drops.
    tests_run++;
    if (m_valid_o !== 1'b1 || m_beam_o !== IW'(7) || dropped_o !== DW'(1) || pending_o !== oh(7)) begin
      tests_failed++;
      $display("FAIL stall_hold: valid=%0b beam=%0d drop=%0d pend=%h, required valid=1 beam=7 drop=1 pend=%h",
               m_valid_o, m_beam_o, dropped_o, pending_o, oh(7));
    end
    n7 = 0;
    for (int k = 0; k < 6; k++) begin
      if (m_valid_o === 1'b1 && m_beam_o === IW'(7)) n7++;
      cycle('0, 1'b1, 1'b0);
    end
    // One transfer drains the held index and one drains the pending bit.
    tests_run++;
    if (n7 !== 2 || dropped_o !== DW'(1)) begin
      tests_failed++;
      $display("FAIL stall_release: transfers_of_7=%0d drop=%0d, required 2 and 1", n7, dropped_o);
    end
  endtask

  task automatic test_all_beams();
    int cnt[NB];
    int prev;
    int bad;
    do_reset();
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    prev = -1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      cycle('1, 1'b1, 1'b0);
      if (m_valid_o === 1'b1) begin
        if (m_beam_o !== IW'((prev < 0) ? 0 : (prev + 1) % NB)) bad++;
        prev = int'(m_beam_o);
        cnt[prev]++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL all_order: out_of_order=%0d, required 0", bad);
    end
    for (int b = 0; b < NB; b++) begin
      tests_run++;
      if (cnt[b] < 4 || cnt[b] > 5) begin
        tests_failed++;
        $display("FAIL all_count%0d: grants=%0d, required 4..5", b, cnt[b]);
      end
    end
    // Every cycle from the second one on drops 47 beams and counts one increment.
    tests_run++;
    if (dropped_o !== DW'(199) || pending_o !== '1) begin
      tests_failed++;
      $display("FAIL all_drop: drop=%0d pend=%h, required 199 and all ones", dropped_o, pending_o);
    end
  endtask

  task automatic test_clear();
    do_reset();
    cycle(oh(12), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(oh(12), 1'b0, 1'b0);
    cycle(oh(12), 1'b0, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b1 || pending_o !== oh(12) || dropped_o !== DW'(1)) begin
      tests_failed++;
      $display("FAIL clear_pre: valid=%0b pend=%h drop=%0d, required 1 %h 1", m_valid_o, pending_o, dropped_o, oh(12));
    end
    cycle(oh(9) | oh(12), 1'b0, 1'b1);
    tests_run++;
    if (m_valid_o !== 1'b0 || pending_o !== '0 || dropped_o !== '0) begin
      tests_failed++;
      $display("FAIL clear_post: valid=%0b pend=%h drop=%0d, required all zero", m_valid_o, pending_o, dropped_o);
    end
    // Pointer was 13 before the clear; after it, 5 must come ahead of 40.
    cycle(oh(5) | oh(40), 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b1 || m_beam_o !== IW'(5)) begin
      tests_failed++;
      $display("FAIL clear_rr0: valid=%0b beam=%0d, required 1 and 5", m_valid_o, m_beam_o);
    end
    cycle('0, 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b1 || m_beam_o !== IW'(40)) begin
      tests_failed++;
      $display("FAIL clear_rr1: valid=%0b beam=%0d, required 1 and 40", m_valid_o, m_beam_o);
    end
  endtask

`ifdef BEAM_TRIG_MASK_EN
  task automatic test_mask();
    do_reset();
    mask_v = oh(20);
    cycle(oh(20) | oh(21), 1'b1, 1'b0);
    tests_run++;
    if (pending_o !== oh(21)) begin
      tests_failed++;
      $display("FAIL mask_pend: pend=%h, required %h", pending_o, oh(21));
    end
    cycle(oh(20), 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b1 || m_beam_o !== IW'(21) || dropped_o !== '0) begin
      tests_failed++;
      $display("FAIL mask_out: valid=%0b beam=%0d drop=%0d, required 1 21 0", m_valid_o, m_beam_o, dropped_o);
    end
    cycle('0, 1'b1, 1'b0);
    tests_run++;
    if (m_valid_o !== 1'b0 || pending_o !== '0) begin
      tests_failed++;
      $display("FAIL mask_idle: valid=%0b pend=%h, required 0 0", m_valid_o, pending_o);
    end
    mask_v = '0;
  endtask
`endif

  task automatic test_random();
    logic [NB-1:0] t;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      t = NB'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
`ifdef BEAM_TRIG_MASK_EN
      mask_v = NB'({$urandom, $urandom} & {$urandom, $urandom});
`endif
      cycle(t, $urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);
      tests_run++;
      if (m_valid_o !== mval || (mval && m_beam_o !== IW'(mbeam))) begin
        tests_failed++;
        $display("FAIL rand_out c%0d: valid=%0b beam=%0d, required valid=%0b beam=%0d", c, m_valid_o, m_beam_o, mval, mbeam);
      end
      tests_run++;
      if (pending_o !== model_pend() || dropped_o !== DW'(mdrop)) begin
        tests_failed++;
        $display("FAIL rand_state c%0d: pend=%h drop=%0d, required pend=%h drop=%0d", c, pending_o, dropped_o, model_pend(), mdrop);
      end
    end
    mask_v = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_wrap();
    test_stall();
    test_all_beams();
    test_clear();
`ifdef BEAM_TRIG_MASK_EN
    test_mask();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
